fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and F/D pipeline register of the 5-stage CPU, directly upstream of PC control.
//  Presents the fetch PC to synchronous instruction memory, exports PCPlusOne, and takes back nextPC/branch.
//  Holds the F/D latch and a 1-entry skid buffer, so the 1-cycle memory latency stays correct under stall and redirect.
// PARAMETERS
//  RESET_PC     32'h0  fetch PC loaded on reset
//  IMEM_ADDR_W  12     width of address_imem (low bits of fetch PC)
//  NOP_INSN     32'h0  encoding placed in fd_IR for a bubble
// PORTS
//  clock        in   1            rising-edge clock
//  reset        in   1            synchronous, active-high
//  stall        in   1            hazard unit: hold F/D, issue no new fetch
//  branch       in   1            PC control: redirect taken this cycle
//  nextPC       in   32           PC control: next fetch PC (PCPlusOne or branch target)
//  q_imem       in   32           imem data for the address presented last cycle
//  address_imem out  IMEM_ADDR_W  fpc[IMEM_ADDR_W-1:0]
//  PCPlusOne    out  32           fpc + 1, combinational, wraps mod 2^32
//  flush_dx     out  1            equals branch (combinational); tells D/X to insert a bubble
//  fd_PC        out  32           PC of the instruction held in F/D
//  fd_IR        out  32           instruction held in F/D
//  fd_valid     out  1            F/D holds a real instruction
// BEHAVIOUR
//  State: fpc, infl_v/infl_pc (word in flight), skid_v/skid_pc/skid_ir, the F/D regs.
//  Reset (highest priority, on the clock edge):
//   - fpc=RESET_PC; infl_v=0; skid_v=0.
//   - fd_valid=0, fd_PC=0, fd_IR=NOP_INSN.
//   - Reset mid-stall or mid-redirect discards all state.
//  Word-addressed PC; address_imem = fpc always.
//  Priority each edge: reset > branch > stall > advance.
//  branch=1 (stall ignored):
//   - fpc<=nextPC; infl_v<=0; skid_v<=0.
//   - F/D<=bubble (fd_valid=0, fd_IR=NOP_INSN, fd_PC=0).
//   - The returning wrong-path word is dropped.
//  stall=1:
//   - F/D and fpc hold; infl_v<=0, so no new issue.
//   - If infl_v: skid<={infl_pc,q_imem}, skid_v<=1.
//  advance:
//   - If skid_v: F/D<=skid, skid_v<=0.
//   - Else if infl_v: F/D<={infl_pc,q_imem,1}.
//   - Else: F/D<=bubble.
//   - Always issue: infl_pc<=fpc, infl_v<=1, fpc<=nextPC.
//  Invariant: skid_v and infl_v are never both 1. Assert in sim.
//  Latency: address presented cycle N -> fd_valid with that PC after edge N+1 (2 edges).
//  Redirect penalty: 2 bubbles in F/D after the branch edge.
//  No instruction is skipped or duplicated across any stall length.
// CONFIGURATION
//  FETCH_STATS_EN defined:
//   - Adds outputs fetch_count[31:0] (+1 per edge loading fd_valid=1).
//   - Adds bubble_count[31:0] (+1 per edge loading a bubble, not stall holds).
//   - Both wrap, both reset to 0.
//  FETCH_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Release reset, no stall, imem[i]=i+100:
//   - address_imem 0,1,2,...
//   - fd_valid=1 from 2nd edge; fd_PC 0,1,2 with fd_IR 100,101,102.
//  stall=1 for 3 cycles while PC 5 is in flight:
//   - skid captures it.
//   - After release, fd_PC 5,6,7 consecutive; IR matches; no gap or repeat.
//  branch=1, nextPC=0x40 at fpc=0x10:
//   - Next edge fd_valid=0, fd_IR=0, address_imem=0x40.
//   - fd_PC=0x40 valid two edges later.
//   - Word for 0x10 never reaches F/D.
//  branch=1 and stall=1 together with skid_v=1:
//   - Skid dropped; fpc=nextPC.
//   - F/D bubble; flush_dx=1 that cycle.
//  fpc=32'hFFFFFFFF: PCPlusOne=0; advance -> address_imem=0.
//  reset=1 during a stall with skid full:
//   - Next edge fd_valid=0, address_imem=RESET_PC.
//   - Counters (if FETCH_STATS_EN) = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage and F/D pipeline register of the 5-stage CPU.
// The fetch PC (fpc) is presented to a synchronous instruction memory. The
// word for an address returns one cycle later, so a one-entry "in flight" tag
// records which PC that word belongs to. A one-entry skid buffer catches a
// word that returns while the pipe is stalled, so no instruction is lost or
// repeated across a stall of any length. A redirect (branch) drops the
// in-flight word and the skid contents and loads a bubble into F/D.
//
// Edge priority: reset > branch > stall > advance.
//
// Optional feature (macro FETCH_STATS_EN):
//   defined   -> adds fetch_count / bubble_count statistics outputs
//   undefined -> those ports and counters do not exist
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high
//   stall         in   hazard unit: hold F/D, issue no new fetch
//   branch        in   PC control: redirect taken this cycle
//   nextPC        in   PC control: next fetch PC (PCPlusOne or target)
//   q_imem        in   imem data for the address presented last cycle
//   address_imem  out  fpc[IMEM_ADDR_W-1:0]
//   PCPlusOne     out  fpc + 1 (combinational, wraps mod 2^32)
//   flush_dx      out  equals branch; D/X inserts a bubble
//   fd_PC         out  PC of the instruction held in F/D
//   fd_IR         out  instruction held in F/D
//   fd_valid      out  F/D holds a real instruction
//   fetch_count   out  (FETCH_STATS_EN) edges loading a valid instruction
//   bubble_count  out  (FETCH_STATS_EN) edges loading a bubble
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          IMEM_ADDR_W = 12,
    parameter logic [31:0] NOP_INSN    = 32'h0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch,
    input  logic [31:0]            nextPC,
    input  logic [31:0]            q_imem,
    output logic [IMEM_ADDR_W-1:0] address_imem,
    output logic [31:0]            PCPlusOne,
    output logic                   flush_dx,
    output logic [31:0]            fd_PC,
    output logic [31:0]            fd_IR,
    output logic                   fd_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            bubble_count
`endif
);

    // What the non-reset edge does to the pipe.
    typedef enum logic [1:0] {
        ACT_REDIRECT,
        ACT_HOLD,
        ACT_ADVANCE
    } act_e;

    logic [31:0] r_fpc;
    logic        r_infl_v;
    logic [31:0] r_infl_pc;
    logic        r_skid_v;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_ir;
    logic        r_fd_valid;
    logic [31:0] r_fd_pc;
    logic [31:0] r_fd_ir;

    act_e        w_act;
    logic        w_fd_valid_nxt;
    logic [31:0] w_fd_pc_nxt;
    logic [31:0] w_fd_ir_nxt;

    assign w_act = branch ? ACT_REDIRECT :
                   stall  ? ACT_HOLD     : ACT_ADVANCE;

    // Value F/D takes on a loading edge. Redirect falls through to the
    // bubble defaults, which drops the returning wrong-path word.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        w_fd_valid_nxt = 1'b0;
        w_fd_pc_nxt    = 32'h0;
        w_fd_ir_nxt    = NOP_INSN;
        if (w_act == ACT_ADVANCE) begin
            if (r_skid_v) begin
                // The skid is older than anything in flight; drain it first.
                w_fd_valid_nxt = 1'b1;
                w_fd_pc_nxt    = r_skid_pc;
                w_fd_ir_nxt    = r_skid_ir;
            end else if (r_infl_v) begin
                w_fd_valid_nxt = 1'b1;
                w_fd_pc_nxt    = r_infl_pc;
                w_fd_ir_nxt    = q_imem;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fpc      <= RESET_PC;
            r_infl_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_fd_valid <= 1'b0;
            r_fd_pc    <= 32'h0;
            r_fd_ir    <= NOP_INSN;
        end else begin
            case (w_act)
                ACT_REDIRECT: begin
                    r_fpc    <= nextPC;
                    r_infl_v <= 1'b0;
                    r_skid_v <= 1'b0;
                end
                ACT_HOLD: begin
                    // No new issue; park the returning word so it is not lost.
                    r_infl_v <= 1'b0;
                    if (r_infl_v) begin
                        r_skid_v <= 1'b1;
                    end
                end
                default: begin
                    r_skid_v <= 1'b0;
                    r_infl_v <= 1'b1;
                    r_fpc    <= nextPC;
                end
            endcase
            if (w_act != ACT_HOLD) begin
                r_fd_valid <= w_fd_valid_nxt;
                r_fd_pc    <= w_fd_pc_nxt;
                r_fd_ir    <= w_fd_ir_nxt;
            end
        end
    end

    // Payload registers are qualified by their valid bits.
    // NOTE: data-only storage is deliberately left without reset.
    always_ff @(posedge clock) begin
        if (w_act == ACT_ADVANCE) begin
            r_infl_pc <= r_fpc;
        end
        if (w_act == ACT_HOLD && r_infl_v) begin
            r_skid_pc <= r_infl_pc;
            r_skid_ir <= q_imem;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count  <= 32'h0;
            r_bubble_count <= 32'h0;
        end else if (w_act != ACT_HOLD) begin
            if (w_fd_valid_nxt) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;
`endif

    // The skid only fills from the in-flight slot while issue is blocked.
    a_skid_infl_exclusive: assert property (
        @(posedge clock) disable iff (reset) !(r_skid_v && r_infl_v)
    );

    assign address_imem = r_fpc[IMEM_ADDR_W-1:0];
    assign PCPlusOne    = r_fpc + 32'd1;
    assign flush_dx     = branch;
    assign fd_valid     = r_fd_valid;
    assign fd_PC        = r_fd_pc;
    assign fd_IR        = r_fd_ir;

endmodule

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage
// ----------------------------------------------------------------------------
// Bench for fetch_stage. It plays PC control and the synchronous imem
// (imem[a] = a + 100). The reference model tracks the architectural fetch PC
// and a FIFO of PCs that have been issued but not yet delivered to F/D; an
// advancing edge delivers the oldest such PC, a redirect or reset empties
// the FIFO. Expected F/D contents per edge go into a scoreboard queue that a
// separate monitor pops one cycle-fraction after each rising edge.
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC    = 32'h0;
    localparam int          IMEM_ADDR_W = 12;
    localparam logic [31:0] NOP_INSN    = 32'h0;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   stall;
    logic                   branch;
    logic [31:0]            nextPC;
    logic [31:0]            q_imem = 32'h0;
    logic [IMEM_ADDR_W-1:0] address_imem;
    logic [31:0]            PCPlusOne;
    logic                   flush_dx;
    logic [31:0]            fd_PC;
    logic [31:0]            fd_IR;
    logic                   fd_valid;
`ifdef FETCH_STATS_EN
    logic [31:0]            fetch_count;
    logic [31:0]            bubble_count;
`endif

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .IMEM_ADDR_W(IMEM_ADDR_W),
        .NOP_INSN   (NOP_INSN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .branch      (branch),
        .nextPC      (nextPC),
        .q_imem      (q_imem),
        .address_imem(address_imem),
        .PCPlusOne   (PCPlusOne),
        .flush_dx    (flush_dx),
        .fd_PC       (fd_PC),
        .fd_IR       (fd_IR),
        .fd_valid    (fd_valid)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count),
        .bubble_count(bubble_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] imem_word(input logic [IMEM_ADDR_W-1:0] a);
        return {{(32-IMEM_ADDR_W){1'b0}}, a} + 32'd100;
    endfunction

    // Synchronous instruction memory model.
    always @(posedge clock) q_imem <= imem_word(address_imem);

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] fpc;
        logic [31:0] fc;
        logic [31:0] bc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] exp_fpc = RESET_PC;
    exp_t        exp_fd;
    logic [31:0] exp_fc = 32'h0;
    logic [31:0] exp_bc = 32'h0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, then the reference model's view of that edge.
    task automatic step(input bit rst, input bit stl, input bit br, input logic [31:0] tgt);
        logic [31:0] p;
        reset  = rst;
        stall  = stl;
        branch = br;
        nextPC = br ? tgt : exp_fpc + 32'd1;
        #1;
        check("flush_dx", {31'b0, flush_dx}, {31'b0, br});
        @(posedge clock);
        if (rst) begin
            exp_fpc = RESET_PC;
            pend_q.delete();
            exp_fd.v = 1'b0; exp_fd.pc = 32'h0; exp_fd.ir = NOP_INSN;
            exp_fc = 32'h0;
            exp_bc = 32'h0;
        end else if (br) begin
            exp_fpc = tgt;
            pend_q.delete();
            exp_fd.v = 1'b0; exp_fd.pc = 32'h0; exp_fd.ir = NOP_INSN;
            exp_bc = exp_bc + 32'd1;
        end else if (!stl) begin
            if (pend_q.size() > 0) begin
                p = pend_q.pop_front();
                exp_fd.v = 1'b1; exp_fd.pc = p; exp_fd.ir = imem_word(p[IMEM_ADDR_W-1:0]);
                exp_fc = exp_fc + 32'd1;
            end else begin
                exp_fd.v = 1'b0; exp_fd.pc = 32'h0; exp_fd.ir = NOP_INSN;
                exp_bc = exp_bc + 32'd1;
            end
            pend_q.push_back(exp_fpc);
            exp_fpc = exp_fpc + 32'd1;
        end
        exp_fd.fpc = exp_fpc;
        exp_fd.fc  = exp_fc;
        exp_fd.bc  = exp_bc;
        sb_q.push_back(exp_fd);
        #3;
    endtask

    // Monitor: compares DUT state after every edge with the scoreboard head.
    exp_t m_e;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                m_e = sb_q.pop_front();
                check("fd_valid", {31'b0, fd_valid}, {31'b0, m_e.v});
                check("fd_PC", fd_PC, m_e.pc);
                check("fd_IR", fd_IR, m_e.ir);
                check("address_imem", {{(32-IMEM_ADDR_W){1'b0}}, address_imem},
                      {{(32-IMEM_ADDR_W){1'b0}}, m_e.fpc[IMEM_ADDR_W-1:0]});
                check("PCPlusOne", PCPlusOne, m_e.fpc + 32'd1);
`ifdef FETCH_STATS_EN
                check("fetch_count", fetch_count, m_e.fc);
                check("bubble_count", bubble_count, m_e.bc);
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit          r_rst, r_stl, r_br;
    logic [31:0] r_tgt;

    initial begin
        exp_fd.v = 1'b0; exp_fd.pc = 32'h0; exp_fd.ir = NOP_INSN;
        reset = 1'b1; stall = 1'b0; branch = 1'b0; nextPC = 32'h0;
        #2;

        // Reset, then straight-line fetch 0,1,2,...
        repeat (2) step(1, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);

        // PC 5 in flight, stall three cycles, release.
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0);

        // Redirect to 0x40 while fpc = 0x10 with 0x0F in flight.
        step(0, 0, 1, 32'h0000_000E);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0040);
        repeat (4) step(0, 0, 0, 0);

        // Fill the skid, then branch and stall together.
        repeat (2) step(0, 1, 0, 0);
        step(0, 1, 1, 32'h0000_0080);
        repeat (3) step(0, 0, 0, 0);

        // PC wrap at 32'hFFFFFFFF.
        step(0, 0, 1, 32'hFFFF_FFFF);
        repeat (4) step(0, 0, 0, 0);

        // Reset while stalled with the skid full.
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(199) == 0);
            r_br  = ($urandom_range(7) == 0);
            r_stl = ($urandom_range(3) == 0);
            if ($urandom_range(3) == 0) r_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
            else                        r_tgt = $urandom;
            step(r_rst, r_stl, r_br, r_tgt);
        end

        repeat (4) step(0, 0, 0, 0);
        #10;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
